// File: rtl/waveform_bank_ctrl_pkg.sv
// rtl/waveform_bank_ctrl_pkg.sv - shared types and defaults for the waveform bank controller
//
// Purpose: FSM state encoding and default geometry shared by the controller
//          and its sub-modules.
// Ports:   none (package).
package waveform_bank_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_ARMED  = 2'd3
  } state_e;

  localparam int unsigned DEFAULT_ADDR_W      = 11;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/waveform_bank_ctrl_toggle_sync.sv
// rtl/waveform_bank_ctrl_toggle_sync.sv - toggle synchronizer with edge-detect pulse
//
// Purpose: brings a foreign-domain toggle into pipe_clk through a flop chain and
//          turns every toggle edge into a single-cycle pulse.
// Ports:
//   pipe_clk  in   destination clock
//   reset     in   synchronous, active-high
//   tgl_i     in   asynchronous toggle
//   pulse_o   out  1-cycle pulse per toggle edge
module waveform_bank_ctrl_toggle_sync
  import waveform_bank_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic pipe_clk,
  input  logic reset,
  input  logic tgl_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge pipe_clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tgl_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Any difference between the synchronized level and its previous sample is one edge.
  assign pulse_o = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/waveform_bank_ctrl.sv
// rtl/waveform_bank_ctrl.sv - double-buffered waveform BRAM bank sequencer
//
// Purpose: host loads/verifies the shadow bank over the pipe while playback reads
//          the active bank; a commit swaps banks only at a playback wrap.
// Ports:
//   pipe_clk          in   host pipe clock
//   reset             in   synchronous, active-high
//   start_load_i      in   pulse: load shadow bank from word 0
//   start_verify_i    in   pulse: read shadow bank back from word 0
//   commit_i          in   pulse: request bank swap at next wrap
//   pipe_in_write_i   in   pipe write strobe
//   pipe_out_read_i   in   pipe read strobe
//   pop_wrap_tgl_i    in   pop_clk toggle, flips on each playback wrap
//   bram_addra_o      out  {shadow_bank, word_addr} to BRAM port A
//   bram_wea_o        out  gated BRAM port A write enable
//   active_bank_o     out  bank being played back
//   load_count_o      out  words accepted in current load
//   full_o            out  shadow bank completely loaded
//   overflow_o        out  sticky: write attempted while full
//   swap_done_o       out  1-cycle pulse when active_bank flips
//   state_o           out  current FSM state
module waveform_bank_ctrl
  import waveform_bank_ctrl_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic              pipe_clk,
  input  logic              reset,
  input  logic              start_load_i,
  input  logic              start_verify_i,
  input  logic              commit_i,
  input  logic              pipe_in_write_i,
  input  logic              pipe_out_read_i,
  input  logic              pop_wrap_tgl_i,
  output logic [ADDR_W:0]   bram_addra_o,
  output logic              bram_wea_o,
  output logic              active_bank_o,
  output logic [ADDR_W:0]   load_count_o,
  output logic              full_o,
  output logic              overflow_o,
  output logic              swap_done_o,
  output logic [1:0]        state_o
);

  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   word_addr_q, word_addr_d;
  logic [ADDR_W:0]     load_count_q, load_count_d;
  logic                overflow_q, overflow_d;
  logic                active_bank_q, active_bank_d;
  logic                swap_done_q, swap_done_d;
  logic                wea;
  logic                full;
  logic                wrap_pulse;

  waveform_bank_ctrl_toggle_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_wrap_sync (
    .pipe_clk(pipe_clk),
    .reset   (reset),
    .tgl_i   (pop_wrap_tgl_i),
    .pulse_o (wrap_pulse)
  );

  assign full = (load_count_q == FULL_COUNT);

  always_ff @(posedge pipe_clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      word_addr_q   <= '0;
      load_count_q  <= '0;
      overflow_q    <= 1'b0;
      active_bank_q <= 1'b0;
      swap_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_addr_q   <= word_addr_d;
      load_count_q  <= load_count_d;
      overflow_q    <= overflow_d;
      active_bank_q <= active_bank_d;
      swap_done_q   <= swap_done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    word_addr_d   = word_addr_q;
    load_count_d  = load_count_q;
    overflow_d    = overflow_q;
    active_bank_d = active_bank_q;
    swap_done_d   = 1'b0;
    wea           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_load_i) begin
          state_d      = ST_LOAD;
          word_addr_d  = '0;
          load_count_d = '0;
          overflow_d   = 1'b0;
        end else if (start_verify_i) begin
          state_d     = ST_VERIFY;
          word_addr_d = '0;
        end else if (commit_i) begin
          state_d = ST_ARMED;
        end
      end

      ST_LOAD: begin
        // Write lands in BRAM this cycle; counters advance at the next edge.
        wea = pipe_in_write_i & ~full;
        if (wea) begin
          word_addr_d  = word_addr_q + ADDR_W'(1);
          load_count_d = load_count_q + (ADDR_W+1)'(1);
        end
        if (pipe_in_write_i && full) begin
          overflow_d = 1'b1;
        end
        // Transitions override the counter update; a commit keeps the final write.
        if (start_load_i) begin
          word_addr_d  = '0;
          load_count_d = '0;
          overflow_d   = 1'b0;
        end else if (start_verify_i) begin
          state_d     = ST_VERIFY;
          word_addr_d = '0;
        end else if (commit_i) begin
          state_d = ST_ARMED;
        end
      end

      ST_VERIFY: begin
        if (pipe_out_read_i) begin
          word_addr_d = word_addr_q + ADDR_W'(1);
        end
        if (start_load_i) begin
          state_d      = ST_LOAD;
          word_addr_d  = '0;
          load_count_d = '0;
          overflow_d   = 1'b0;
        end else if (start_verify_i) begin
          word_addr_d = '0;
        end else if (commit_i) begin
          state_d = ST_ARMED;
        end
      end

      ST_ARMED: begin
        // Only wraps seen while already armed count, so playback never swaps mid-period.
        if (start_load_i) begin
          state_d      = ST_LOAD;
          word_addr_d  = '0;
          load_count_d = '0;
          overflow_d   = 1'b0;
        end else if (wrap_pulse) begin
          active_bank_d = ~active_bank_q;
          swap_done_d   = 1'b1;
          state_d       = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bram_addra_o  = {~active_bank_q, word_addr_q};
  assign bram_wea_o    = wea;
  assign active_bank_o = active_bank_q;
  assign load_count_o  = load_count_q;
  assign full_o        = full;
  assign overflow_o    = overflow_q;
  assign swap_done_o   = swap_done_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_waveform_bank_ctrl.sv
// tb/tb_waveform_bank_ctrl.sv - directed self-checking bench for waveform_bank_ctrl
module tb_waveform_bank_ctrl;

  localparam int ADDR_W = 11;

  logic              pipe_clk = 1'b0;
  logic              reset = 1'b1;
  logic              start_load = 1'b0;
  logic              start_verify = 1'b0;
  logic              commit = 1'b0;
  logic              pin_wr = 1'b0;
  logic              pout_rd = 1'b0;
  logic              wrap_tgl = 1'b0;
  logic [ADDR_W:0]   addra;
  logic              wea;
  logic              active_bank;
  logic [ADDR_W:0]   load_count;
  logic              full;
  logic              overflow;
  logic              swap_done;
  logic [1:0]        state;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  waveform_bank_ctrl #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .pipe_clk       (pipe_clk),
    .reset          (reset),
    .start_load_i   (start_load),
    .start_verify_i (start_verify),
    .commit_i       (commit),
    .pipe_in_write_i(pin_wr),
    .pipe_out_read_i(pout_rd),
    .pop_wrap_tgl_i (wrap_tgl),
    .bram_addra_o   (addra),
    .bram_wea_o     (wea),
    .active_bank_o  (active_bank),
    .load_count_o   (load_count),
    .full_o         (full),
    .overflow_o     (overflow),
    .swap_done_o    (swap_done),
    .state_o        (state)
  );

  always #5 pipe_clk = ~pipe_clk;

  task automatic tick();
    @(posedge pipe_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_addra", 32'(addra), 32'h800);
    chk("rst_wea", 32'(wea), 32'd0);
    chk("rst_active", 32'(active_bank), 32'd0);
    chk("rst_count", 32'(load_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_swap", 32'(swap_done), 32'd0);
    tick();

    // 1: load 5 words into shadow bank 1, commit, swap on wrap
    start_load = 1'b1; tick(); start_load = 1'b0;
    chk("t1_state_load", 32'(state), 32'd1);
    for (int k = 0; k < 5; k++) begin
      pin_wr = 1'b1; #1;
      chk("t1_wea", 32'(wea), 32'd1);
      chk("t1_addra", 32'(addra), 32'h800 + 32'(k));
      tick();
    end
    pin_wr = 1'b0;
    chk("t1_count", 32'(load_count), 32'd5);
    commit = 1'b1; tick(); commit = 1'b0;
    chk("t1_armed", 32'(state), 32'd3);
    wrap_tgl = ~wrap_tgl;
    tick(); tick();
    chk("t1_no_swap_early", 32'(swap_done), 32'd0);
    chk("t1_bank_early", 32'(active_bank), 32'd0);
    tick();
    chk("t1_swap_done", 32'(swap_done), 32'd1);
    chk("t1_active", 32'(active_bank), 32'd1);
    chk("t1_idle", 32'(state), 32'd0);
    tick();
    chk("t1_swap_pulse_end", 32'(swap_done), 32'd0);

    // 2: fill shadow bank 0 completely, then overflow
    start_load = 1'b1; tick(); start_load = 1'b0;
    pin_wr = 1'b1;
    for (int k = 0; k < 2047; k++) tick();
    chk("t2_count_2047", 32'(load_count), 32'd2047);
    chk("t2_not_full", 32'(full), 32'd0);
    tick();
    chk("t2_count_2048", 32'(load_count), 32'd2048);
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_wea_blocked", 32'(wea), 32'd0);
    tick();
    pin_wr = 1'b0;
    chk("t2_overflow", 32'(overflow), 32'd1);
    chk("t2_count_sat", 32'(load_count), 32'd2048);

    // 3: verify readback addresses on shadow bank 0
    start_verify = 1'b1; tick(); start_verify = 1'b0;
    chk("t3_state", 32'(state), 32'd2);
    chk("t3_addra0", 32'(addra), 32'h000);
    for (int k = 1; k <= 3; k++) begin
      pout_rd = 1'b1; pin_wr = 1'b1; #1;
      chk("t3_wea", 32'(wea), 32'd0);
      tick();
      chk("t3_addra", 32'(addra), 32'(k));
    end
    pout_rd = 1'b0; pin_wr = 1'b0;

    // 4: commit cancelled by start_load; wraps in LOAD ignored
    commit = 1'b1; tick(); commit = 1'b0;
    chk("t4_armed", 32'(state), 32'd3);
    start_load = 1'b1; tick(); start_load = 1'b0;
    chk("t4_load", 32'(state), 32'd1);
    wrap_tgl = ~wrap_tgl;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_no_swap", 32'(swap_done), 32'd0);
    end
    chk("t4_active", 32'(active_bank), 32'd1);
    chk("t4_still_load", 32'(state), 32'd1);

    // 5: write in the commit cycle is accepted
    pin_wr = 1'b1; commit = 1'b1; #1;
    chk("t5_wea", 32'(wea), 32'd1);
    tick();
    pin_wr = 1'b0; commit = 1'b0;
    chk("t5_armed", 32'(state), 32'd3);
    chk("t5_count", 32'(load_count), 32'd1);
    wrap_tgl = ~wrap_tgl;
    tick(); tick(); tick();
    chk("t5_swap", 32'(swap_done), 32'd1);
    chk("t5_active", 32'(active_bank), 32'd0);
    // wraps while IDLE do nothing, strobes ignored
    wrap_tgl = ~wrap_tgl;
    pin_wr = 1'b1; #1;
    chk("t5_idle_wea", 32'(wea), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t5_idle_no_swap", 32'(swap_done), 32'd0);
    end
    pin_wr = 1'b0;
    chk("t5_idle_active", 32'(active_bank), 32'd0);
    chk("t5_idle_state", 32'(state), 32'd0);

    // 6: reset while ARMED with wrap toggling
    commit = 1'b1; tick(); commit = 1'b0;
    chk("t6_armed", 32'(state), 32'd3);
    wrap_tgl = ~wrap_tgl;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wrap_tgl = ~wrap_tgl;
      tick();
      chk("t6_rst_state", 32'(state), 32'd0);
      chk("t6_rst_swap", 32'(swap_done), 32'd0);
      chk("t6_rst_active", 32'(active_bank), 32'd0);
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_post_swap", 32'(swap_done), 32'd0);
      chk("t6_post_state", 32'(state), 32'd0);
    end
    chk("t6_post_active", 32'(active_bank), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
